// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: source count, register offsets, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package irq_pkg;

   // Default number of interrupt sources (TC0, TC1, external, spares)
   localparam int NSRC_DEF = 6;

   // Width of a source index; limits the design to at most 8 sources
   localparam int ID_W = 3;

   // Word offsets within the bridge window (reg_addr[3:2])
   localparam logic [1:0] REG_MASK = 2'd0;
   localparam logic [1:0] REG_MODE = 2'd1;
   localparam logic [1:0] REG_PEND = 2'd2;
   localparam logic [1:0] REG_CUR  = 2'd3;

   // Request handshake states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt vector.
// Latency: purely combinational.
// Backpressure: none; output follows input in the same cycle.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int N = NSRC_DEF
) (
   input  logic [N-1:0]    req,
   output logic            any,
   output logic [ID_W-1:0] id
);

   // Scan from the top down so the lowest set index is the last one written
   always_comb begin
      any = |req;
      id  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge/level capture, masking, fixed priority, single outstanding request with ack/EOI.
// Latency: edge source rising before edge N -> pending after N, irq_req after N+1; level sources one edge earlier.
// Backpressure: irq_req holds a frozen irq_id until irq_ack; no new request is raised until software writes CUR (EOI).
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NSRC = NSRC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] hw_irq,
   input  logic [3:2]      reg_addr,
   input  logic            reg_we,
   input  logic [31:0]     reg_wdata,
   output logic [31:0]     reg_rdata,
   output logic            irq_req,
   output logic [2:0]      irq_id,
   input  logic            irq_ack
);

   state_t            state_q;
   state_t            state_d;
   logic [NSRC-1:0]   mask_q;
   logic [NSRC-1:0]   mode_q;
   logic [NSRC-1:0]   epend_q;
   logic [NSRC-1:0]   hw_q;
   logic [ID_W-1:0]   id_q;
   logic              cur_vld_q;
   logic [ID_W-1:0]   cur_id_q;

   logic              wr_mask;
   logic              wr_mode;
   logic              wr_cur;
   logic [NSRC-1:0]   mask_d;
   logic [NSRC-1:0]   mode_d;
   logic [NSRC-1:0]   epend_d;
   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   pending;
   logic [NSRC-1:0]   eligible;
   logic [NSRC-1:0]   id_onehot;
   logic [NSRC-1:0]   ack_clr;
   logic              id_elig;
   logic              take;
   logic              load_id;
   logic              eoi;
   logic              enc_any;
   logic [ID_W-1:0]   enc_id;
   logic              unused_wdata;

   assign wr_mask = reg_we && (reg_addr == REG_MASK);
   assign wr_mode = reg_we && (reg_addr == REG_MODE);
   assign wr_cur  = reg_we && (reg_addr == REG_CUR);

   // Only the low NSRC write-data bits carry register content
   assign unused_wdata = ^reg_wdata[31:NSRC];

   assign mask_d = wr_mask ? reg_wdata[NSRC-1:0] : mask_q;
   assign mode_d = wr_mode ? reg_wdata[NSRC-1:0] : mode_q;

   // Edge sources report the stored capture, level sources mirror the pin
   assign rise     = hw_irq & ~hw_q;
   assign pending  = (mode_q & epend_q) | (~mode_q & hw_irq);
   assign eligible = pending & mask_q;

   assign id_onehot = {{(NSRC-1){1'b0}}, 1'b1} << id_q;
   assign id_elig   = |(eligible & id_onehot);

   assign take    = (state_q == REQ) && irq_ack;
   assign load_id = (state_q == IDLE) && enc_any;
   assign eoi     = (state_q == SERVICE) && wr_cur;
   assign ack_clr = take ? id_onehot : '0;

   // A new rising edge beats the ack clear; bits leaving edge mode drop their capture
   assign epend_d = ((epend_q & ~ack_clr) | rise) & mode_d;

   irq_prio_enc #(
      .N (NSRC)
   ) u_prio_enc (
      .req (eligible),
      .any (enc_any),
      .id  (enc_id)
   );

   // Next-state and request output for the handshake FSM
   always_comb begin
      state_d = state_q;
      irq_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (enc_any) begin
               state_d = REQ;
            end
         end
         REQ: begin
            irq_req = 1'b1;
            if (irq_ack) begin
               state_d = SERVICE;
            end else if (!id_elig) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (wr_cur) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Configuration, capture and in-service registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q    <= '0;
         mode_q    <= '0;
         epend_q   <= '0;
         hw_q      <= '0;
         id_q      <= '0;
         cur_vld_q <= 1'b0;
         cur_id_q  <= '0;
      end else begin
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         epend_q <= epend_d;
         hw_q    <= hw_irq;
         if (load_id) begin
            id_q <= enc_id;
         end
         if (take) begin
            cur_vld_q <= 1'b1;
            cur_id_q  <= id_q;
         end else if (eoi) begin
            cur_vld_q <= 1'b0;
            cur_id_q  <= '0;
         end
      end
   end

   assign irq_id = id_q;

   // Register readback, zero-extended
   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         REG_MASK: reg_rdata = {{(32-NSRC){1'b0}}, mask_q};
         REG_MODE: reg_rdata = {{(32-NSRC){1'b0}}, mode_q};
         REG_PEND: reg_rdata = {{(32-NSRC){1'b0}}, pending};
         REG_CUR:  reg_rdata = {cur_vld_q, {(31-ID_W){1'b0}}, cur_id_q};
         default:  reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: vector table, directed corner sequences, random run vs. reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_arbiter;

   localparam int NSRC = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic [NSRC-1:0] hw_irq;
   logic [3:2]      reg_addr;
   logic            reg_we;
   logic [31:0]     reg_wdata;
   logic [31:0]     reg_rdata;
   logic            irq_req;
   logic [2:0]      irq_id;
   logic            irq_ack;

   always #5 clk = ~clk;

   irq_arbiter #(.NSRC(NSRC)) dut (
      .clk       (clk),
      .reset     (reset),
      .hw_irq    (hw_irq),
      .reg_addr  (reg_addr),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input bit we, input logic [1:0] addr, input logic [31:0] wd,
                        input logic [5:0] hw, input bit ack);
      reg_we    = we;
      reg_addr  = addr;
      reg_wdata = wd;
      hw_irq    = hw;
      irq_ack   = ack;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          we;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [5:0]  hw;
      bit          ack;
      bit          exp_req;
      logic [2:0]  exp_id;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit we, input logic [1:0] addr, input logic [31:0] wd,
                               input logic [5:0] hw, input bit ack, input bit er,
                               input logic [2:0] ei, input logic [31:0] ed);
      vec_t v;
      v.we = we; v.addr = addr; v.wd = wd; v.hw = hw; v.ack = ack;
      v.exp_req = er; v.exp_id = ei; v.exp_rd = ed;
      return v;
   endfunction

   // ---------------- reference model ----------------
   // phase: 0 nothing requested, 1 waiting for ack, 2 being serviced
   bit [5:0] m_mask, m_mode, m_epend, m_prev;
   int       m_phase, m_id, m_cur_id;
   bit       m_cur_vld;

   function automatic bit [5:0] m_pend_vec(input bit [5:0] hw);
      bit [5:0] v;
      for (int i = 0; i < 6; i++) v[i] = m_mode[i] ? m_epend[i] : hw[i];
      return v;
   endfunction

   task automatic model_edge(input bit we, input int addr, input bit [31:0] wd,
                             input bit [5:0] hw, input bit ack);
      bit [5:0] pend;
      bit [5:0] nmask;
      bit [5:0] nmode;
      bit [5:0] nep;
      int       first;
      int       clr;
      bit       id_ok;
      pend  = m_pend_vec(hw);
      first = -1;
      for (int i = 0; i < 6; i++) if (first < 0 && pend[i] && m_mask[i]) first = i;
      id_ok = pend[m_id] && m_mask[m_id];
      nmask = (we && addr == 0) ? wd[5:0] : m_mask;
      nmode = (we && addr == 1) ? wd[5:0] : m_mode;
      clr   = -1;
      case (m_phase)
         0: if (first >= 0) begin m_phase = 1; m_id = first; end
         1: begin
            if (ack) begin
               m_phase = 2; m_cur_vld = 1'b1; m_cur_id = m_id; clr = m_id;
            end else if (!id_ok) begin
               m_phase = 0;
            end
         end
         default: if (we && addr == 3) begin m_phase = 0; m_cur_vld = 1'b0; m_cur_id = 0; end
      endcase
      for (int i = 0; i < 6; i++)
         nep[i] = nmode[i] && ((hw[i] && !m_prev[i]) || (m_epend[i] && i != clr));
      m_epend = nep;
      m_mask  = nmask;
      m_mode  = nmode;
      m_prev  = hw;
   endtask

   function automatic logic [31:0] model_rd(input int addr, input bit [5:0] hw);
      case (addr)
         0:       return {26'b0, m_mask};
         1:       return {26'b0, m_mode};
         2:       return {26'b0, m_pend_vec(hw)};
         default: return {m_cur_vld, 28'b0, m_cur_id[2:0]};
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit [5:0] hw_r;
      bit       we_r;
      bit       ack_r;
      int       addr_r;
      bit [31:0] wd_r;

      // ---------------- reset state ----------------
      reset = 1'b0;
      drive(0, 2'd3, 0, 6'h00, 0);
      #1;
      check("reset irq_req", 32'(irq_req), 0);
      check("reset irq_id", 32'(irq_id), 0);
      check("reset CUR", reg_rdata, 0);
      reg_addr = 2'd0;
      #1;
      check("reset MASK", reg_rdata, 0);
      tick;
      check("reset held irq_req", 32'(irq_req), 0);
      #3 reset = 1'b1;

      // ---------------- table: basic flow, simultaneous arrival, frozen id ----------------
      tbl.push_back(mk(1, 0, 32'h3F, 6'h00, 0, 0, 0, 32'h0000003F));
      tbl.push_back(mk(1, 1, 32'h01, 6'h00, 0, 0, 0, 32'h00000001));
      tbl.push_back(mk(0, 2, 0,      6'h01, 0, 0, 0, 32'h00000001));
      tbl.push_back(mk(0, 2, 0,      6'h00, 0, 1, 0, 32'h00000001));
      tbl.push_back(mk(0, 3, 0,      6'h00, 1, 0, 0, 32'h80000000));
      tbl.push_back(mk(0, 2, 0,      6'h00, 0, 0, 0, 32'h00000000));
      tbl.push_back(mk(1, 3, 0,      6'h00, 0, 0, 0, 32'h00000000));
      tbl.push_back(mk(1, 1, 32'h05, 6'h00, 0, 0, 0, 32'h00000005));
      tbl.push_back(mk(0, 2, 0,      6'h05, 0, 0, 0, 32'h00000005));
      tbl.push_back(mk(0, 2, 0,      6'h05, 0, 1, 0, 32'h00000005));
      tbl.push_back(mk(0, 3, 0,      6'h05, 1, 0, 0, 32'h80000000));
      tbl.push_back(mk(0, 2, 0,      6'h00, 0, 0, 0, 32'h00000004));
      tbl.push_back(mk(1, 3, 0,      6'h00, 0, 0, 0, 32'h00000000));
      tbl.push_back(mk(0, 2, 0,      6'h00, 0, 1, 2, 32'h00000004));
      tbl.push_back(mk(0, 2, 0,      6'h01, 0, 1, 2, 32'h00000005));
      tbl.push_back(mk(0, 2, 0,      6'h01, 0, 1, 2, 32'h00000005));
      tbl.push_back(mk(0, 3, 0,      6'h00, 1, 0, 2, 32'h80000002));
      tbl.push_back(mk(1, 3, 0,      6'h00, 0, 0, 2, 32'h00000000));
      tbl.push_back(mk(0, 2, 0,      6'h00, 0, 1, 0, 32'h00000001));
      tbl.push_back(mk(0, 3, 0,      6'h00, 1, 0, 0, 32'h80000000));
      tbl.push_back(mk(1, 3, 0,      6'h00, 0, 0, 0, 32'h00000000));
      tbl.push_back(mk(0, 2, 0,      6'h00, 1, 0, 0, 32'h00000000));

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].hw, tbl[k].ack);
         tick;
         check($sformatf("vec%0d irq_req", k), 32'(irq_req), 32'(tbl[k].exp_req));
         check($sformatf("vec%0d irq_id", k), 32'(irq_id), 32'(tbl[k].exp_id));
         check($sformatf("vec%0d rdata", k), reg_rdata, tbl[k].exp_rd);
      end

      // ---------------- level source masked off while requesting ----------------
      drive(0, 2, 0, 6'h02, 0); tick;
      check("lvl req", 32'(irq_req), 1);
      check("lvl id", 32'(irq_id), 1);
      drive(1, 0, 32'h3D, 6'h02, 0); tick;
      check("lvl mask write not yet effective", 32'(irq_req), 1);
      drive(0, 0, 0, 6'h02, 0); tick;
      check("lvl req dropped", 32'(irq_req), 0);
      check("lvl mask readback", reg_rdata, 32'h3D);
      drive(0, 2, 0, 6'h02, 0); tick;
      check("lvl stays idle", 32'(irq_req), 0);
      check("lvl pending live", reg_rdata, 32'h02);
      drive(1, 0, 32'h3F, 6'h00, 0); tick;

      // ---------------- reset during SERVICE ----------------
      drive(1, 1, 32'h01, 6'h00, 0); tick;
      drive(0, 2, 0, 6'h01, 0); tick;
      drive(0, 2, 0, 6'h00, 0); tick;
      drive(0, 3, 0, 6'h00, 1); tick;
      check("svc CUR before reset", reg_rdata, 32'h80000000);
      drive(0, 3, 0, 6'h00, 0);
      #3 reset = 1'b0;
      #1;
      check("async reset CUR", reg_rdata, 0);
      check("async reset irq_req", 32'(irq_req), 0);
      check("async reset irq_id", 32'(irq_id), 0);
      reg_addr = 2'd0; #1;
      check("async reset MASK", reg_rdata, 0);
      reg_addr = 2'd1; #1;
      check("async reset MODE", reg_rdata, 0);
      reg_addr = 2'd2; #1;
      check("async reset PENDING", reg_rdata, 0);
      tick;
      hw_irq = 6'h08;
      #3 reset = 1'b1;
      drive(0, 2, 0, 6'h08, 0); tick;
      tick;
      check("masked level no req", 32'(irq_req), 0);
      check("masked level pending", reg_rdata, 32'h08);

      // ---------------- ack coincident with new rising edge ----------------
      drive(1, 0, 32'h3F, 6'h00, 0); tick;
      drive(1, 1, 32'h01, 6'h00, 0); tick;
      drive(0, 2, 0, 6'h01, 0); tick;
      drive(0, 2, 0, 6'h00, 0); tick;
      check("coinc first req", 32'(irq_req), 1);
      drive(0, 2, 0, 6'h01, 1); tick;
      check("coinc in service", 32'(irq_req), 0);
      check("coinc pending kept", reg_rdata, 32'h01);
      drive(1, 3, 0, 6'h00, 0); tick;
      drive(0, 2, 0, 6'h00, 0); tick;
      check("coinc re-request", 32'(irq_req), 1);
      check("coinc re-request id", 32'(irq_id), 0);

      // ---------------- random run against the reference model ----------------
      reset = 1'b0;
      drive(0, 0, 0, 6'h00, 0);
      tick;
      #2 reset = 1'b1;
      m_mask = 0; m_mode = 0; m_epend = 0; m_prev = 0;
      m_phase = 0; m_id = 0; m_cur_id = 0; m_cur_vld = 1'b0;
      hw_r = 6'h00;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 6; b++) if ($urandom_range(3) == 0) hw_r[b] = ~hw_r[b];
         we_r   = ($urandom_range(5) == 0);
         addr_r = int'($urandom_range(3));
         wd_r   = $urandom;
         if ($urandom_range(1) == 0) wd_r[5:0] = wd_r[5:0] | 6'h15;
         ack_r  = ($urandom_range(2) == 0);
         model_edge(we_r, addr_r, wd_r, hw_r, ack_r);
         drive(we_r, 2'(addr_r), wd_r, hw_r, ack_r);
         tick;
         check($sformatf("rnd%0d irq_req", c), 32'(irq_req), 32'(m_phase == 1));
         check($sformatf("rnd%0d irq_id", c), 32'(irq_id), 32'(m_id));
         check($sformatf("rnd%0d rdata@%0d", c, addr_r), reg_rdata, model_rd(addr_r, hw_r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
